// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle EX stalls, redirect flushes, EX forwarding.
// Optional stall/flush performance counters are enabled with the HAZARD_PERF_CNT_EN macro.
module hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_we,
    input  logic              ex_load,
    input  logic              ex_mc_start,
    input  logic              mc_done,
    input  logic              ex_redirect,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_we,
    input  logic              wb_we,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              flush_id,
    output logic              flush_ex,
    output logic              flush_mem,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);

    typedef enum logic [1:0] {RUN, LOAD_WAIT, MC_BUSY} state_t;

    state_t     state_q, state_d;
    logic [1:0] lcnt_q, lcnt_d;
    logic       load_use_hit;

    assign load_use_hit = ex_load && ex_we && (ex_rd != '0) &&
                          ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                           (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_d   = state_q;
        lcnt_d    = lcnt_q;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        flush_mem = 1'b0;
        case (state_q)
            RUN: begin
                // A multi-cycle op in EX takes precedence over load-use and redirect handling
                if (ex_mc_start) begin
                    if (!mc_done) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        flush_mem = 1'b1;
                        state_d   = MC_BUSY;
                    end
                end else if (ex_redirect) begin
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                end else if (load_use_hit) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                    if (LOAD_LAT > 1) begin
                        lcnt_d  = 2'(LOAD_LAT - 1);
                        state_d = LOAD_WAIT;
                    end
                end
            end
            LOAD_WAIT: begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
                lcnt_d   = lcnt_q - 2'd1;
                if (lcnt_q == 2'd1) begin
                    state_d = RUN;
                end
            end
            MC_BUSY: begin
                if (mc_done) begin
                    state_d = RUN;
                end else begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    stall_ex  = 1'b1;
                    flush_mem = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                lcnt_d  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            lcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
        end
    end

    // MEM result is younger than WB, so it wins when both match
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_we && (mem_rd != '0) && (mem_rd == ex_rs1)) begin
            fwd_a = 2'b10;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == ex_rs1)) begin
            fwd_a = 2'b01;
        end
        if (mem_we && (mem_rd != '0) && (mem_rd == ex_rs2)) begin
            fwd_b = 2'b10;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == ex_rs2)) begin
            fwd_b = 2'b01;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + CNT_W'(stall_if);
        flush_events_d = flush_events_q + CNT_W'(flush_id);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus and are
// compared every cycle against a bubble-count reference model.
module tb_hazard_ctrl;
    localparam int AW = 5;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
    logic id_use_rs1, id_use_rs2, ex_we, ex_load, ex_mc_start, mc_done, ex_redirect;
    logic mem_we, wb_we;

    logic sif1, sid1, sex1, fid1, fex1, fmem1;
    logic [1:0] fa1, fb1;
    logic [CW-1:0] sc1, fe1;
    logic sif3, sid3, sex3, fid3, fex3, fmem3;
    logic [1:0] fa3, fb3;
    logic [CW-1:0] sc3, fe3;

    hazard_ctrl #(.REG_AW(AW), .LOAD_LAT(1), .CNT_W(CW)) u_l1 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_we(ex_we),
        .ex_load(ex_load), .ex_mc_start(ex_mc_start), .mc_done(mc_done),
        .ex_redirect(ex_redirect), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_rd(mem_rd),
        .wb_rd(wb_rd), .mem_we(mem_we), .wb_we(wb_we), .stall_if(sif1), .stall_id(sid1),
        .stall_ex(sex1), .flush_id(fid1), .flush_ex(fex1), .flush_mem(fmem1),
        .fwd_a(fa1), .fwd_b(fb1), .stall_cycles(sc1), .flush_events(fe1));

    hazard_ctrl #(.REG_AW(AW), .LOAD_LAT(3), .CNT_W(CW)) u_l3 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_we(ex_we),
        .ex_load(ex_load), .ex_mc_start(ex_mc_start), .mc_done(mc_done),
        .ex_redirect(ex_redirect), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_rd(mem_rd),
        .wb_rd(wb_rd), .mem_we(mem_we), .wb_we(wb_we), .stall_if(sif3), .stall_id(sid3),
        .stall_ex(sex3), .flush_id(fid3), .flush_ex(fex3), .flush_mem(fmem3),
        .fwd_a(fa3), .fwd_b(fb3), .stall_cycles(sc3), .flush_events(fe3));

    int passed = 0;
    int total  = 0;

    // Reference state: outstanding extra load bubbles, and whether a multi-cycle op is pending
    int            rem[2];
    bit            mcb[2];
    logic [CW-1:0] msc[2];
    logic [CW-1:0] mfe[2];
    int            lat[2] = '{1, 3};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    function automatic logic [1:0] fwd(input logic [AW-1:0] rs);
        if (mem_we && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (wb_we && wb_rd != 0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Output order: stall_if stall_id stall_ex flush_id flush_ex flush_mem fwd_a fwd_b
    task automatic model(input int i, output logic [9:0] o, output int nr, output bit nm);
        logic a_if, a_id, a_ex, f_id, f_ex, f_mem;
        bit hit;
        {a_if, a_id, a_ex, f_id, f_ex, f_mem} = 6'b0;
        nr = rem[i];
        nm = mcb[i];
        hit = ex_load && ex_we && ex_rd != 0 &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (rem[i] > 0) begin
            {a_if, a_id, f_ex} = 3'b111;
            nr = rem[i] - 1;
        end else if (mcb[i]) begin
            if (!mc_done) {a_if, a_id, a_ex, f_mem} = 4'b1111;
            else nm = 1'b0;
        end else if (ex_mc_start) begin
            if (!mc_done) begin
                {a_if, a_id, a_ex, f_mem} = 4'b1111;
                nm = 1'b1;
            end
        end else if (ex_redirect) begin
            {f_id, f_ex} = 2'b11;
        end else if (hit) begin
            {a_if, a_id, f_ex} = 3'b111;
            nr = lat[i] - 1;
        end
        o = {a_if, a_id, a_ex, f_id, f_ex, f_mem, fwd(ex_rs1), fwd(ex_rs2)};
    endtask

    // Called just after a falling edge with inputs already applied
    task automatic cycle(input string tag);
        logic [9:0] o[2];
        int nr[2];
        bit nm[2];
        #1;
        for (int i = 0; i < 2; i++) model(i, o[i], nr[i], nm[i]);
        chk($sformatf("%s.ctl_l1", tag), 64'({sif1, sid1, sex1, fid1, fex1, fmem1, fa1, fb1}), 64'(o[0]));
        chk($sformatf("%s.ctl_l3", tag), 64'({sif3, sid3, sex3, fid3, fex3, fmem3, fa3, fb3}), 64'(o[1]));
`ifdef HAZARD_PERF_CNT_EN
        chk($sformatf("%s.cnt_l1", tag), {sc1, fe1}, {msc[0], mfe[0]});
        chk($sformatf("%s.cnt_l3", tag), {sc3, fe3}, {msc[1], mfe[1]});
`else
        chk($sformatf("%s.cnt_l1", tag), {sc1, fe1}, 64'd0);
        chk($sformatf("%s.cnt_l3", tag), {sc3, fe3}, 64'd0);
`endif
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                rem[i] = nr[i];
                mcb[i] = nm[i];
                msc[i] = msc[i] + CW'(o[i][9]);
                mfe[i] = mfe[i] + CW'(o[i][6]);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        {id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd} = '0;
        {id_use_rs1, id_use_rs2, ex_we, ex_load, ex_mc_start, mc_done, ex_redirect} = '0;
        {mem_we, wb_we} = '0;
    endtask

    task automatic do_reset(input string tag);
        idle();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rem[i] = 0;
            mcb[i] = 1'b0;
            msc[i] = '0;
            mfe[i] = '0;
        end
        cycle(tag);
        rst = 1'b0;
    endtask

    task automatic set_load_use(input logic [AW-1:0] rd, input logic [AW-1:0] rs, input logic use1);
        ex_load = 1'b1;
        ex_we = 1'b1;
        ex_rd = rd;
        id_rs1 = rs;
        id_use_rs1 = use1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk);
        do_reset("reset");

        set_load_use(5, 5, 1'b1);
        cycle("lu_detect");
        idle();
        cycle("lu_wait1");
        cycle("lu_wait2");
        cycle("lu_after");

        set_load_use(0, 0, 1'b1);
        cycle("lu_rd0");
        set_load_use(5, 5, 1'b0);
        cycle("lu_nouse");
        idle();
        ex_load = 1'b1; ex_we = 1'b1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1'b1;
        cycle("lu_rs2");
        idle();
        cycle("lu_rs2_w1");
        cycle("lu_rs2_w2");

        ex_mc_start = 1'b1;
        cycle("mc_start");
        ex_mc_start = 1'b0;
        for (int k = 0; k < 3; k++) cycle("mc_busy");
        mc_done = 1'b1;
        cycle("mc_done");
        mc_done = 1'b0;
        cycle("mc_after");
        ex_mc_start = 1'b1; mc_done = 1'b1;
        cycle("mc_same");
        ex_load = 1'b1; ex_we = 1'b1; ex_rd = 4; id_rs1 = 4; id_use_rs1 = 1'b1; mc_done = 1'b0;
        cycle("mc_vs_load");
        idle();
        mc_done = 1'b1;
        cycle("mc_vs_load_done");
        idle();

        set_load_use(5, 5, 1'b1);
        ex_redirect = 1'b1;
        cycle("redir_lu");
        idle();
        cycle("redir_after");

        mem_rd = 7; wb_rd = 7; mem_we = 1'b1; wb_we = 1'b1; ex_rs1 = 7; ex_rs2 = 0;
        cycle("fwd_mem");
        mem_we = 1'b0;
        cycle("fwd_wb");
        mem_we = 1'b1; mem_rd = 0; wb_rd = 0; ex_rs1 = 0;
        cycle("fwd_zero");
        idle();

        ex_mc_start = 1'b1;
        cycle("mcr_start");
        ex_mc_start = 1'b0;
        cycle("mcr_busy");
        do_reset("rst_mid_mc");
        cycle("rst_mid_mc_after");

        set_load_use(12, 12, 1'b1);
        cycle("cnt_lu");
        idle();
        cycle("cnt_w1");
        cycle("cnt_w2");
        cycle("cnt_end");

        for (int n = 0; n < 400; n++) begin
            id_rs1 = AW'($urandom_range(0, 7));
            id_rs2 = AW'($urandom_range(0, 7));
            ex_rd  = AW'($urandom_range(0, 7));
            ex_rs1 = AW'($urandom_range(0, 7));
            ex_rs2 = AW'($urandom_range(0, 7));
            mem_rd = AW'($urandom_range(0, 7));
            wb_rd  = AW'($urandom_range(0, 7));
            id_use_rs1 = 1'($urandom);
            id_use_rs2 = 1'($urandom);
            ex_we   = 1'($urandom);
            ex_load = ($urandom_range(0, 2) == 0);
            mem_we  = 1'($urandom);
            wb_we   = 1'($urandom);
            ex_mc_start = ($urandom_range(0, 9) == 0);
            mc_done     = ($urandom_range(0, 3) == 0);
            ex_redirect = !ex_mc_start && ($urandom_range(0, 5) == 0);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
